log_export_ctrl: RTL and testbench

// Transmit side of the VR log-transfer (START_VIEW) message; the install controller on the peer consumes it.
// - On start_log_export, snapshots the log bounds and emits one header beat.
// - Then streams every log header entry, each followed by that entry's data lines, as a
//   NOC_DATA_W-wide val/rdy stream toward the NoC/UDP TX path.
// - Reads come from the header-log and data-log RAMs, both synchronous with 1-cycle read latency.

---
 rtl/vr_log_pkg.sv | 36 +++
 rtl/log_export_out_fifo.sv | 67 ++++++
 rtl/log_export_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_log_export_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_log_pkg.sv
// Package: vr_log_pkg
// Beat-format constants for the VR log-transfer (START_VIEW) message and the
// export state enum. The install side on the peer decodes the same layout.
//
// Field offsets are counted in bits down from the beat MSB:
//   header beat : first_log_op | last_commit | hdr_log_tail (zero-extended) | zeros
//   entry word  : op_num | data_addr | n_lines | don't-care (forwarded unchanged)
package vr_log_pkg;

  localparam int NOC_DATA_W_DEF       = 512;
  localparam int INT_W_DEF            = 64;
  localparam int LOG_HDR_DEPTH_W_DEF  = 6;
  localparam int LOG_DATA_DEPTH_W_DEF = 8;
  localparam int ENTRY_LINES_W_DEF    = 8;
  localparam int OUT_FIFO_DEPTH_DEF   = 4;

  // Header beat offsets from MSB
  localparam int HDR_FIRST_OP_OFS = 0;
  localparam int HDR_COMMIT_OFS   = INT_W_DEF;
  localparam int HDR_TAIL_OFS     = 2 * INT_W_DEF;

  // Entry word offsets from MSB
  localparam int ENT_OP_OFS      = 0;
  localparam int ENT_ADDR_OFS    = INT_W_DEF;
  localparam int ENT_N_LINES_OFS = INT_W_DEF + LOG_DATA_DEPTH_W_DEF;

  typedef enum logic [2:0] {
    READY,
    SEND_HDR,
    RD_ENTRY,
    CAP_ENTRY,
    RD_DATA,
    DRAIN
  } log_export_state_e;

endpackage

// File: rtl/log_export_out_fifo.sv
// Module: log_export_out_fifo
// Output buffer for the export stream. Each entry is {last, beat}.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data write one entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   head            head entry, held stable until popped
//   valid           FIFO non-empty
//   count           current occupancy, used by the producer for read credit
module log_export_out_fifo #(
  parameter int W     = 513,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != FULL);

  assign head  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/log_export_ctrl.sv
// Module: log_export_ctrl
// Transmit side of the VR log-transfer message. On start it snapshots the
// log bounds, emits a header beat, then every header-log entry followed by
// that entry's data lines, read from two 1-cycle-latency RAMs.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start_log_export            start pulse, honoured only while log_export_rdy
//   log_export_rdy              idle
//   first_log_op, last_commit,
//   hdr_log_tail                message bounds, sampled at start
//   hdr_log_rd_req_*/resp_data  header-log RAM read port
//   data_log_rd_req_*/resp_data data-log RAM read port
//   export_dst_req_*            output stream (val/data/last/padbytes)
//   dst_export_req_rdy          downstream ready
//   fsm_state                   current state, for observation
//
// Handshake: a beat transfers on a cycle where export_dst_req_val and
// dst_export_req_rdy are both high; while val is high and rdy is low the
// beat, val and last hold steady. Beats come from the head of the output
// FIFO. A RAM read issues only while fifo count + reads in flight is below
// the FIFO depth; a pop in the same cycle is not credited, so the FIFO can
// never overflow.
module log_export_ctrl
  import vr_log_pkg::*;
#(
  parameter int NOC_DATA_W       = NOC_DATA_W_DEF,
  parameter int INT_W            = INT_W_DEF,
  parameter int LOG_HDR_DEPTH_W  = LOG_HDR_DEPTH_W_DEF,
  parameter int LOG_DATA_DEPTH_W = LOG_DATA_DEPTH_W_DEF,
  parameter int ENTRY_LINES_W    = ENTRY_LINES_W_DEF,
  parameter int OUT_FIFO_DEPTH   = OUT_FIFO_DEPTH_DEF,
  parameter int NOC_PADBYTES_W   = $clog2(NOC_DATA_W / 8)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_log_export,
  output logic                          log_export_rdy,
  input  logic [INT_W-1:0]              first_log_op,
  input  logic [INT_W-1:0]              last_commit,
  input  logic [LOG_HDR_DEPTH_W:0]      hdr_log_tail,
  output logic                          hdr_log_rd_req_val,
  output logic [LOG_HDR_DEPTH_W-1:0]    hdr_log_rd_req_addr,
  input  logic [NOC_DATA_W-1:0]         hdr_log_rd_resp_data,
  output logic                          data_log_rd_req_val,
  output logic [LOG_DATA_DEPTH_W-1:0]   data_log_rd_req_addr,
  input  logic [NOC_DATA_W-1:0]         data_log_rd_resp_data,
  output logic                          export_dst_req_val,
  output logic [NOC_DATA_W-1:0]         export_dst_req,
  output logic                          export_dst_req_last,
  output logic [NOC_PADBYTES_W-1:0]     export_dst_req_padbytes,
  input  logic                          dst_export_req_rdy,
  output log_export_state_e             fsm_state
);

  localparam int FIFO_W = NOC_DATA_W + 1;
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [LOG_HDR_DEPTH_W:0] IDX_ONE  = (LOG_HDR_DEPTH_W + 1)'(1);
  localparam logic [ENTRY_LINES_W-1:0] LINE_ONE = ENTRY_LINES_W'(1);

  log_export_state_e state_q, state_d;

  logic [INT_W-1:0]            first_op_q;
  logic [INT_W-1:0]            commit_q;
  logic [LOG_HDR_DEPTH_W:0]    tail_q;
  logic [LOG_HDR_DEPTH_W:0]    entry_idx_q, entry_idx_d;
  logic [LOG_DATA_DEPTH_W-1:0] data_addr_q, data_addr_d;
  logic [ENTRY_LINES_W-1:0]    n_lines_q, n_lines_d;
  logic [ENTRY_LINES_W-1:0]    line_cnt_q, line_cnt_d;
  logic                        inflight_q, inflight_d;
  logic                        pend_last_q, pend_last_d;

  logic                        push;
  logic [FIFO_W-1:0]           push_data;
  logic [FIFO_W-1:0]           fifo_head;
  logic                        fifo_valid;
  logic [CNT_W-1:0]            fifo_count;
  logic                        credit;
  logic                        last_entry;
  logic                        final_line;
  logic [LOG_DATA_DEPTH_W-1:0] resp_addr;
  logic [ENTRY_LINES_W-1:0]    resp_n_lines;
  logic [NOC_DATA_W-1:0]       hdr_beat;

  assign credit     = (int'(fifo_count) + int'(inflight_q)) < OUT_FIFO_DEPTH;
  // entry_idx is one bit wider than the RAM address so a full log
  // (tail == 2^LOG_HDR_DEPTH_W) terminates instead of aliasing to 0.
  assign last_entry = (entry_idx_q + IDX_ONE) == tail_q;
  assign final_line = (line_cnt_q + LINE_ONE) == n_lines_q;

  assign resp_addr    = hdr_log_rd_resp_data[NOC_DATA_W-1-INT_W -: LOG_DATA_DEPTH_W];
  assign resp_n_lines = hdr_log_rd_resp_data[NOC_DATA_W-1-INT_W-LOG_DATA_DEPTH_W -: ENTRY_LINES_W];

  assign hdr_beat = {first_op_q, commit_q,
                     {(INT_W-LOG_HDR_DEPTH_W-1){1'b0}}, tail_q,
                     {(NOC_DATA_W-3*INT_W){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= READY;
      first_op_q  <= '0;
      commit_q    <= '0;
      tail_q      <= '0;
      entry_idx_q <= '0;
      data_addr_q <= '0;
      n_lines_q   <= '0;
      line_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_idx_q <= entry_idx_d;
      data_addr_q <= data_addr_d;
      n_lines_q   <= n_lines_d;
      line_cnt_q  <= line_cnt_d;
      inflight_q  <= inflight_d;
      pend_last_q <= pend_last_d;
      if (state_q == READY && start_log_export) begin
        first_op_q <= first_log_op;
        commit_q   <= last_commit;
        tail_q     <= hdr_log_tail;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    entry_idx_d          = entry_idx_q;
    data_addr_d          = data_addr_q;
    n_lines_d            = n_lines_q;
    line_cnt_d           = line_cnt_q;
    inflight_d           = 1'b0;
    pend_last_d          = pend_last_q;
    push                 = 1'b0;
    push_data            = '0;
    hdr_log_rd_req_val   = 1'b0;
    hdr_log_rd_req_addr  = '0;
    data_log_rd_req_val  = 1'b0;
    data_log_rd_req_addr = '0;

    // A data read issued last cycle lands now, whatever state we moved to.
    // Header-log responses are only ever consumed in CAP_ENTRY.
    if (inflight_q && state_q != CAP_ENTRY) begin
      push      = 1'b1;
      push_data = {pend_last_q, data_log_rd_resp_data};
    end

    case (state_q)
      READY: begin
        if (start_log_export) begin
          entry_idx_d = '0;
          state_d     = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (credit) begin
          push      = 1'b1;
          push_data = {(tail_q == '0), hdr_beat};
          state_d   = (tail_q == '0) ? DRAIN : RD_ENTRY;
        end
      end
      RD_ENTRY: begin
        if (credit) begin
          hdr_log_rd_req_val  = 1'b1;
          hdr_log_rd_req_addr = entry_idx_q[LOG_HDR_DEPTH_W-1:0];
          inflight_d          = 1'b1;
          state_d             = CAP_ENTRY;
        end
      end
      CAP_ENTRY: begin
        push        = 1'b1;
        push_data   = {(resp_n_lines == '0) && last_entry, hdr_log_rd_resp_data};
        data_addr_d = resp_addr;
        n_lines_d   = resp_n_lines;
        line_cnt_d  = '0;
        if (resp_n_lines != '0) begin
          state_d = RD_DATA;
        end else if (last_entry) begin
          state_d = DRAIN;
        end else begin
          entry_idx_d = entry_idx_q + IDX_ONE;
          state_d     = RD_ENTRY;
        end
      end
      RD_DATA: begin
        if (credit) begin
          data_log_rd_req_val  = 1'b1;
          data_log_rd_req_addr = data_addr_q + LOG_DATA_DEPTH_W'(line_cnt_q);
          inflight_d           = 1'b1;
          pend_last_d          = final_line && last_entry;
          if (!final_line) begin
            line_cnt_d = line_cnt_q + LINE_ONE;
          end else if (last_entry) begin
            state_d = DRAIN;
          end else begin
            entry_idx_d = entry_idx_q + IDX_ONE;
            state_d     = RD_ENTRY;
          end
        end
      end
      DRAIN: begin
        if (fifo_count == '0 && !inflight_q) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  log_export_out_fifo #(
    .W     (FIFO_W),
    .DEPTH (OUT_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (export_dst_req_val && dst_export_req_rdy),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // FIFO storage is not reset, so gate the head to keep outputs 0 when empty.
  assign export_dst_req_val      = fifo_valid;
  assign export_dst_req          = fifo_valid ? fifo_head[NOC_DATA_W-1:0] : '0;
  assign export_dst_req_last     = fifo_valid && fifo_head[NOC_DATA_W];
  assign export_dst_req_padbytes = '0;
  assign log_export_rdy          = (state_q == READY);
  assign fsm_state               = state_q;

endmodule

// File: tb/tb_log_export_ctrl.sv
// Testbench: tb_log_export_ctrl
// Table of whole-message scenarios plus hand-written sequences for the
// explicit two-entry example, address wrap, back-pressure and mid-message
// reset. Header/data RAMs are modelled here with 1-cycle read latency.
module tb_log_export_ctrl;
  import vr_log_pkg::*;

  localparam int W   = 512;
  localparam int IW  = 64;
  localparam int HAW = 6;
  localparam int DAW = 8;
  localparam int PBW = 6;
  localparam int BW  = W + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              start_log_export;
  logic              log_export_rdy;
  logic [IW-1:0]     first_log_op;
  logic [IW-1:0]     last_commit;
  logic [HAW:0]      hdr_log_tail;
  logic              hdr_log_rd_req_val;
  logic [HAW-1:0]    hdr_log_rd_req_addr;
  logic [W-1:0]      hdr_log_rd_resp_data;
  logic              data_log_rd_req_val;
  logic [DAW-1:0]    data_log_rd_req_addr;
  logic [W-1:0]      data_log_rd_resp_data;
  logic              export_dst_req_val;
  logic [W-1:0]      export_dst_req;
  logic              export_dst_req_last;
  logic [PBW-1:0]    export_dst_req_padbytes;
  logic              dst_export_req_rdy;
  log_export_state_e fsm_state;

  log_export_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_log_export        (start_log_export),
    .log_export_rdy          (log_export_rdy),
    .first_log_op            (first_log_op),
    .last_commit             (last_commit),
    .hdr_log_tail            (hdr_log_tail),
    .hdr_log_rd_req_val      (hdr_log_rd_req_val),
    .hdr_log_rd_req_addr     (hdr_log_rd_req_addr),
    .hdr_log_rd_resp_data    (hdr_log_rd_resp_data),
    .data_log_rd_req_val     (data_log_rd_req_val),
    .data_log_rd_req_addr    (data_log_rd_req_addr),
    .data_log_rd_resp_data   (data_log_rd_resp_data),
    .export_dst_req_val      (export_dst_req_val),
    .export_dst_req          (export_dst_req),
    .export_dst_req_last     (export_dst_req_last),
    .export_dst_req_padbytes (export_dst_req_padbytes),
    .dst_export_req_rdy      (dst_export_req_rdy),
    .fsm_state               (fsm_state)
  );

  // ---------------- RAM models ----------------
  logic [W-1:0]   hdr_ram  [64];
  logic [W-1:0]   data_ram [256];
  int             hdr_rd_cnt = 0;
  int             data_rd_cnt = 0;
  logic [DAW-1:0] data_rd_log [4096];

  always @(posedge clk) begin
    if (hdr_log_rd_req_val) begin
      hdr_log_rd_resp_data <= hdr_ram[hdr_log_rd_req_addr];
      hdr_rd_cnt <= hdr_rd_cnt + 1;
    end
    if (data_log_rd_req_val) begin
      data_log_rd_resp_data <= data_ram[data_log_rd_req_addr];
      data_rd_log[data_rd_cnt[11:0]] <= data_log_rd_req_addr;
      data_rd_cnt <= data_rd_cnt + 1;
    end
  end

  // ---------------- beat builders ----------------
  function automatic logic [W-1:0] entry_word(logic [63:0] op, logic [7:0] a, logic [7:0] n, int idx);
    logic [31:0] tag;
    tag = 32'hE0E00000 | idx;
    entry_word = {op, a, n, 400'b0, tag};
  endfunction

  function automatic logic [W-1:0] data_word(int a);
    logic [31:0] t;
    t = 32'hDA7A0000 | (a & 255);
    data_word = {16{t}};
  endfunction

  function automatic logic [W-1:0] hdr_word(logic [63:0] op, logic [63:0] cm, int tail);
    hdr_word = {op, cm, 64'(tail), 320'b0};
  endfunction

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            ent_addr [64];
  int            ent_n    [64];
  int            errors = 0;
  int            checks = 0;
  int            rdy_pct;
  bit            force_stall;
  bit            prev_stall;
  logic [BW-1:0] prev_beat;
  int            stall_bad;
  int            pad_bad;

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_beat(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_entry(int i, logic [63:0] op, int a, int n);
    hdr_ram[i]  = entry_word(op, 8'(a), 8'(n), i);
    ent_addr[i] = a;
    ent_n[i]    = n;
  endtask

  // Expected message: header, then each entry followed by its lines; last on final beat only.
  task automatic build_model(int tail, logic [63:0] op, logic [63:0] cm);
    logic [BW-1:0] t;
    exp_q.delete();
    exp_q.push_back({1'b0, hdr_word(op, cm, tail)});
    for (int i = 0; i < tail; i++) begin
      exp_q.push_back({1'b0, hdr_ram[i]});
      for (int l = 0; l < ent_n[i]; l++)
        exp_q.push_back({1'b0, data_ram[(ent_addr[i] + l) % 256]});
    end
    t = exp_q.pop_back();
    t[W] = 1'b1;
    exp_q.push_back(t);
  endtask

  // One clock: sample outputs at negedge, choose rdy for the next posedge.
  task automatic cycle();
    @(negedge clk);
    if (prev_stall && (!export_dst_req_val || {export_dst_req_last, export_dst_req} !== prev_beat))
      stall_bad++;
    if (export_dst_req_padbytes !== '0) pad_bad++;
    dst_export_req_rdy = force_stall ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (export_dst_req_val && dst_export_req_rdy)
      got_q.push_back({export_dst_req_last, export_dst_req});
    prev_stall = export_dst_req_val && !dst_export_req_rdy;
    prev_beat  = {export_dst_req_last, export_dst_req};
  endtask

  task automatic run_msg(string tag, int tail, logic [63:0] op, logic [63:0] cm,
                         int pct, int stall_n, bit busy_start);
    int iter;
    int h0;
    int d0;
    rdy_pct = pct;
    got_q.delete();
    stall_bad = 0;
    pad_bad = 0;
    prev_stall = 1'b0;
    force_stall = (stall_n > 0);
    first_log_op = op;
    last_commit = cm;
    hdr_log_tail = 7'(tail);
    h0 = hdr_rd_cnt;
    d0 = data_rd_cnt;
    start_log_export = 1'b1;
    cycle();
    start_log_export = 1'b0;
    // later input changes must not affect the latched snapshot
    first_log_op = 64'hFFFF_FFFF_FFFF_FFFF;
    last_commit = 64'h0BAD;
    hdr_log_tail = 7'd5;
    chk_int({tag, " val_1cyc"}, int'(export_dst_req_val), 0);
    iter = 0;
    while (!log_export_rdy && iter < 3000) begin
      cycle();
      iter++;
      if (iter == 1) chk_int({tag, " hdr_latency"}, int'(export_dst_req_val), 1);
      if (busy_start && iter == 4) begin
        start_log_export = 1'b1;
        first_log_op = 64'hDEAD;
        hdr_log_tail = 7'd1;
      end
      if (busy_start && iter == 5) start_log_export = 1'b0;
      if (stall_n > 0 && iter == stall_n) begin
        chk_int({tag, " stall_reads"}, (hdr_rd_cnt - h0) + (data_rd_cnt - d0), 3);
        chk_int({tag, " stall_val"}, int'(export_dst_req_val), 1);
        chk_beat({tag, " stall_head"}, {export_dst_req_last, export_dst_req},
                 {(tail == 0), hdr_word(op, cm, tail)});
        force_stall = 1'b0;
      end
    end
    if (iter >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles", tag, iter);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    chk_int({tag, " beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk_beat($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
    chk_int({tag, " stall_stable"}, stall_bad, 0);
    chk_int({tag, " padbytes"}, pad_bad, 0);
    chk_int({tag, " rdy_back"}, int'(log_export_rdy), 1);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    string       name;
    int          tail;
    logic [63:0] op;
    logic [63:0] cm;
    int          n_lines;
    int          base;
    int          pct;
    bit          busy;
    int          exp_beats;   // 1 + tail*(1+n_lines)
  } scen_t;

  scen_t scen [4];
  int    d0;
  int    cnt;

  initial begin
    for (int a = 0; a < 256; a++) data_ram[a] = data_word(a);
    for (int i = 0; i < 64; i++) set_entry(i, 64'h0, 0, 0);

    scen[0] = '{"empty",  0, 64'd5,   64'd4,   0, 8'h00, 100, 1'b0, 1};
    scen[1] = '{"rand4x4", 4, 64'd200, 64'd190, 4, 8'h20, 50,  1'b1, 21};
    scen[2] = '{"full64", 64, 64'd300, 64'd299, 0, 8'h00, 100, 1'b0, 65};
    scen[3] = '{"rand3x2", 3, 64'd400, 64'd398, 2, 8'h40, 30,  1'b0, 10};

    rst = 1'b1;
    start_log_export = 1'b0;
    first_log_op = '0;
    last_commit = '0;
    hdr_log_tail = '0;
    dst_export_req_rdy = 1'b0;
    rdy_pct = 0;
    force_stall = 1'b0;
    prev_stall = 1'b0;
    repeat (3) cycle();
    chk_int("rst val", int'(export_dst_req_val), 0);
    chk_int("rst last", int'(export_dst_req_last), 0);
    chk_int("rst rdy", int'(log_export_rdy), 1);
    chk_int("rst hdr_rd", int'(hdr_log_rd_req_val), 0);
    chk_int("rst data_rd", int'(data_log_rd_req_val), 0);
    chk_int("rst state", int'(fsm_state), int'(READY));
    rst = 1'b0;
    cycle();

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < scen[s].tail; i++)
        set_entry(i, scen[s].op + 64'(i) + 1, (scen[s].base + i * scen[s].n_lines) % 256, scen[s].n_lines);
      build_model(scen[s].tail, scen[s].op, scen[s].cm);
      run_msg(scen[s].name, scen[s].tail, scen[s].op, scen[s].cm, scen[s].pct, 0, scen[s].busy);
      chk_int({scen[s].name, " hand_beats"}, got_q.size(), scen[s].exp_beats);
    end

    // Two entries with different line counts, expected beats written out.
    set_entry(0, 64'd7, 8'h10, 3);
    set_entry(1, 64'd8, 8'h13, 1);
    exp_q.delete();
    exp_q.push_back({1'b0, hdr_word(64'h11, 64'h22, 2)});
    exp_q.push_back({1'b0, entry_word(64'd7, 8'h10, 8'd3, 0)});
    exp_q.push_back({1'b0, data_word(8'h10)});
    exp_q.push_back({1'b0, data_word(8'h11)});
    exp_q.push_back({1'b0, data_word(8'h12)});
    exp_q.push_back({1'b0, entry_word(64'd8, 8'h13, 8'd1, 1)});
    exp_q.push_back({1'b1, data_word(8'h13)});
    run_msg("two_entry", 2, 64'h11, 64'h22, 100, 0, 1'b0);

    // Data address wrap FE, FF, 00.
    set_entry(0, 64'd9, 8'hFE, 3);
    build_model(1, 64'h31, 64'h30);
    d0 = data_rd_cnt;
    run_msg("wrap", 1, 64'h31, 64'h30, 100, 0, 1'b0);
    chk_int("wrap n_reads", data_rd_cnt - d0, 3);
    chk_int("wrap addr0", int'(data_rd_log[12'(d0)]), 8'hFE);
    chk_int("wrap addr1", int'(data_rd_log[12'(d0 + 1)]), 8'hFF);
    chk_int("wrap addr2", int'(data_rd_log[12'(d0 + 2)]), 8'h00);

    // Back-pressure: rdy held low until the FIFO fills, then released.
    set_entry(0, 64'd60, 8'h80, 3);
    set_entry(1, 64'd61, 8'h83, 3);
    build_model(2, 64'h51, 64'h50);
    run_msg("stall", 2, 64'h51, 64'h50, 100, 20, 1'b0);

    // Reset after the third beat, then a clean message.
    rdy_pct = 100;
    got_q.delete();
    prev_stall = 1'b0;
    first_log_op = 64'h71;
    last_commit = 64'h70;
    hdr_log_tail = 7'd2;
    start_log_export = 1'b1;
    cycle();
    start_log_export = 1'b0;
    cnt = 0;
    while (got_q.size() < 3 && cnt < 200) begin
      cycle();
      cnt++;
    end
    chk_int("rst_mid beats_before", got_q.size(), 3);
    rst = 1'b1;
    cycle();
    chk_int("rst_mid val", int'(export_dst_req_val), 0);
    chk_int("rst_mid rdy", int'(log_export_rdy), 1);
    rst = 1'b0;
    cycle();
    chk_int("rst_mid val_after", int'(export_dst_req_val), 0);
    build_model(2, 64'h81, 64'h80);
    run_msg("after_rst", 2, 64'h81, 64'h80, 100, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
